// File: rtl/coffee_dispense_sequencer.sv
// Turns each coffee sale into an ordered, timed powder/cream/sugar/water valve sequence with a one-deep sale queue.
// Build option CUP_SENSE_EN adds Cup_Present: wait for a cup before powder, and pause valves while the cup is absent.
module coffee_dispense_sequencer #(
   parameter int unsigned COFFEE_CYC = 8,
   parameter int unsigned CREAM_CYC  = 4,
   parameter int unsigned SUGAR_CYC  = 3,
   parameter int unsigned WATER_CYC  = 10
) (
   input  logic       Clock,
   input  logic       nReset,
   input  logic       Coffee,
   input  logic       Water,
   input  logic       Cream,
   input  logic       Sugar,
`ifdef CUP_SENSE_EN
   input  logic       Cup_Present,
`endif
   output logic       Valve_Coffee,
   output logic       Valve_Cream,
   output logic       Valve_Sugar,
   output logic       Valve_Water,
   output logic       Busy,
   output logic       Done,
   output logic       Overrun,
   output logic [7:0] Cup_Count
);

   typedef enum logic [2:0] {
      S_IDLE, S_POWDER, S_CREAM, S_SUGAR, S_WATER, S_DONE, S_WAIT_CUP
   } state_e;

   localparam logic [7:0] COFFEE_LD = 8'(COFFEE_CYC - 1);
   localparam logic [7:0] CREAM_LD  = 8'(CREAM_CYC - 1);
   localparam logic [7:0] SUGAR_LD  = 8'(SUGAR_CYC - 1);
   localparam logic [7:0] WATER_LD  = 8'(WATER_CYC - 1);

`ifdef CUP_SENSE_EN
   localparam state_e START_ST = S_WAIT_CUP;
`else
   localparam state_e START_ST = S_POWDER;
`endif

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] rec_q, rec_d;        // {W, C, S}
   logic [2:0] pend_q, pend_d;
   logic       pend_vld_q, pend_vld_d;
   logic [7:0] cups_q, cups_d;
   logic       ovr_q, ovr_d;
   logic       coffee_q;
   logic       trig;
   logic       cup_ok;
   logic [2:0] new_rec;

`ifdef CUP_SENSE_EN
   assign cup_ok = Cup_Present;
`else
   assign cup_ok = 1'b1;
`endif

   assign trig    = Coffee & ~coffee_q;
   assign new_rec = {Water, Cream, Sugar};

   // Phase order is fixed; a phase is skipped when its recipe flag is clear.
   function automatic state_e next_phase(input state_e cur, input logic [2:0] r);
      if (cur == S_POWDER && r[1]) return S_CREAM;
      if ((cur == S_POWDER || cur == S_CREAM) && r[0]) return S_SUGAR;
      if (cur != S_WATER && r[2]) return S_WATER;
      return S_DONE;
   endfunction

   function automatic logic [7:0] phase_load(input state_e s);
      case (s)
         S_CREAM: return CREAM_LD;
         S_SUGAR: return SUGAR_LD;
         S_WATER: return WATER_LD;
         default: return 8'd0;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rec_d      = rec_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      cups_d     = cups_q;
      ovr_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (trig) begin
               state_d = START_ST;
               rec_d   = new_rec;
               cnt_d   = COFFEE_LD;
            end
         end
         S_DONE: begin
            cups_d = cups_q + 8'd1;
            if (pend_vld_q) begin
               // A sale arriving now refills the slot the departing recipe frees.
               state_d    = START_ST;
               rec_d      = pend_q;
               cnt_d      = COFFEE_LD;
               pend_vld_d = trig;
               pend_d     = new_rec;
            end else if (trig) begin
               state_d = START_ST;
               rec_d   = new_rec;
               cnt_d   = COFFEE_LD;
            end else begin
               state_d = S_IDLE;
            end
         end
`ifdef CUP_SENSE_EN
         S_WAIT_CUP: begin
            if (cup_ok) state_d = S_POWDER;
         end
`endif
         S_POWDER, S_CREAM, S_SUGAR, S_WATER: begin
            if (cup_ok) begin
               if (cnt_q == 8'd0) begin
                  state_d = next_phase(state_q, rec_q);
                  cnt_d   = phase_load(next_phase(state_q, rec_q));
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (trig && state_q != S_IDLE && state_q != S_DONE) begin
         if (pend_vld_q) begin
            ovr_d = 1'b1;
         end else begin
            pend_vld_d = 1'b1;
            pend_d     = new_rec;
         end
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         rec_q      <= 3'd0;
         pend_q     <= 3'd0;
         pend_vld_q <= 1'b0;
         cups_q     <= 8'd0;
         ovr_q      <= 1'b0;
         coffee_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rec_q      <= rec_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         cups_q     <= cups_d;
         ovr_q      <= ovr_d;
         coffee_q   <= Coffee;
      end
   end

   assign Valve_Coffee = (state_q == S_POWDER) & cup_ok;
   assign Valve_Cream  = (state_q == S_CREAM)  & cup_ok;
   assign Valve_Sugar  = (state_q == S_SUGAR)  & cup_ok;
   assign Valve_Water  = (state_q == S_WATER)  & cup_ok;
   assign Busy         = (state_q != S_IDLE);
   assign Done         = (state_q == S_DONE);
   assign Overrun      = ovr_q;
   assign Cup_Count    = cups_q;

endmodule

// File: tb/tb_coffee_dispense_sequencer.sv
// Randomized and directed bench for coffee_dispense_sequencer against a per-cycle timeline reference model.
module tb_coffee_dispense_sequencer;

   logic       Clock = 1'b0;
   logic       nReset = 1'b0;
   logic       Coffee = 1'b0, Water = 1'b0, Cream = 1'b0, Sugar = 1'b0;
`ifdef CUP_SENSE_EN
   logic       Cup_Present = 1'b1;
`endif
   logic       Valve_Coffee, Valve_Cream, Valve_Sugar, Valve_Water;
   logic       Busy, Done, Overrun;
   logic [7:0] Cup_Count;

   coffee_dispense_sequencer dut (
      .Clock(Clock), .nReset(nReset), .Coffee(Coffee), .Water(Water),
      .Cream(Cream), .Sugar(Sugar),
`ifdef CUP_SENSE_EN
      .Cup_Present(Cup_Present),
`endif
      .Valve_Coffee(Valve_Coffee), .Valve_Cream(Valve_Cream),
      .Valve_Sugar(Valve_Sugar), .Valve_Water(Valve_Water),
      .Busy(Busy), .Done(Done), .Overrun(Overrun), .Cup_Count(Cup_Count)
   );

   always #5 Clock = ~Clock;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: each sale expands into a list of per-cycle activity codes.
   localparam int P_IDLE = 0, P_COF = 1, P_CRM = 2, P_SUG = 3, P_WAT = 4, P_DONE = 5;
   int       tl[$];
   bit       m_pend_vld;
   bit [2:0] m_pend_rec;
   int       m_cups;
   bit       m_ovr;
   bit       m_prev;

   function automatic void m_start(input bit [2:0] r);
      for (int i = 0; i < 8; i++) tl.push_back(P_COF);
      if (r[1]) for (int i = 0; i < 4;  i++) tl.push_back(P_CRM);
      if (r[0]) for (int i = 0; i < 3;  i++) tl.push_back(P_SUG);
      if (r[2]) for (int i = 0; i < 10; i++) tl.push_back(P_WAT);
      tl.push_back(P_DONE);
   endfunction

   function automatic void m_reset();
      tl.delete();
      m_pend_vld = 1'b0;
      m_pend_rec = 3'd0;
      m_cups     = 0;
      m_ovr      = 1'b0;
      m_prev     = 1'b0;
   endfunction

   function automatic void m_step(input bit cof, input bit [2:0] r);
      bit t;
      int cur;
      t      = cof && !m_prev;
      m_prev = cof;
      m_ovr  = 1'b0;
      if (tl.size() == 0) begin
         if (t) m_start(r);
      end else begin
         cur = tl.pop_front();
         if (cur == P_DONE) begin
            m_cups++;
            if (m_pend_vld) begin
               m_start(m_pend_rec);
               m_pend_vld = t;
               m_pend_rec = r;
            end else if (t) begin
               m_start(r);
            end
         end else if (t) begin
            if (m_pend_vld) m_ovr = 1'b1;
            else begin
               m_pend_vld = 1'b1;
               m_pend_rec = r;
            end
         end
      end
   endfunction

   task automatic check_outputs();
      int cur;
      cur = (tl.size() == 0) ? P_IDLE : tl[0];
      check("valve_coffee", Valve_Coffee, cur == P_COF);
      check("valve_cream",  Valve_Cream,  cur == P_CRM);
      check("valve_sugar",  Valve_Sugar,  cur == P_SUG);
      check("valve_water",  Valve_Water,  cur == P_WAT);
      check("busy",         Busy,         cur != P_IDLE);
      check("done",         Done,         cur == P_DONE);
      check("overrun",      Overrun,      m_ovr);
      check("cup_count",    Cup_Count,    m_cups % 256);
   endtask

   // Drive inputs for the next edge, advance the model, then check at the falling edge.
   task automatic cyc(input bit cof, input bit [2:0] r);
      Coffee = cof;
      {Water, Cream, Sugar} = r;
      @(posedge Clock);
      m_step(cof, r);
      @(negedge Clock);
      check_outputs();
   endtask

   task automatic do_reset();
      nReset = 1'b0;
      #1;
      check("rst_valves", {Valve_Coffee, Valve_Cream, Valve_Sugar, Valve_Water}, 0);
      check("rst_busy",   Busy, 0);
      check("rst_done",   Done, 0);
      check("rst_ovr",    Overrun, 0);
      check("rst_cups",   Cup_Count, 0);
      m_reset();
      @(posedge Clock);
      #1 nReset = 1'b1;
      @(negedge Clock);
   endtask

   initial begin
      @(negedge Clock);
      do_reset();

      // Black coffee, cycle-exact timing from the trigger edge.
      cyc(1'b1, 3'b100);
      for (int k = 2; k <= 21; k++) begin
         cyc(1'b1, 3'b100);
         check("t1_coffee", Valve_Coffee, (k <= 8));
         check("t1_water",  Valve_Water,  (k >= 9 && k <= 18));
         check("t1_done",   Done,         (k == 19));
         check("t1_busy",   Busy,         (k <= 19));
      end
      check("t1_cups", Cup_Count, 1);

      // Full recipe.
      do_reset();
      cyc(1'b1, 3'b111);
      for (int k = 2; k <= 27; k++) begin
         cyc(1'b0, 3'b000);
         check("t2_coffee", Valve_Coffee, (k <= 8));
         check("t2_cream",  Valve_Cream,  (k >= 9 && k <= 12));
         check("t2_sugar",  Valve_Sugar,  (k >= 13 && k <= 15));
         check("t2_water",  Valve_Water,  (k >= 16 && k <= 25));
         check("t2_done",   Done,         (k == 26));
      end

      // Coffee high across reset release and held: a single sale.
      Coffee = 1'b1;
      do_reset();
      for (int k = 0; k < 30; k++) cyc(1'b1, 3'b000);
      for (int k = 0; k < 20; k++) cyc(1'b0, 3'b000);
      check("t3_cups", Cup_Count, 1);

      // Triggers at 0, 5, 7: queue one, drop one.
      do_reset();
      for (int j = 0; j <= 40; j++) begin
         cyc((j == 0 || j == 5 || j == 7), 3'b100);
         if (j + 1 == 8) check("t4_overrun", Overrun, 1);
         if (j + 1 >= 1 && j + 1 <= 38) check("t4_busy", Busy, 1);
         if (j + 1 == 39) check("t4_cups", Cup_Count, 2);
      end

      // Reset mid-sequence with a sale pending.
      do_reset();
      for (int j = 0; j < 12; j++) cyc((j == 0 || j == 5), 3'b100);
      do_reset();
      for (int j = 0; j < 40; j++) begin
         cyc(1'b0, 3'b000);
         check("t5_no_done", Done, 0);
      end

      // Back-to-back minimal recipes: counter wraps past 255.
      do_reset();
      for (int j = 0; j < 2600; j++) cyc((j % 10) < 5, 3'b000);
      check("t6_wrap", Cup_Count, m_cups % 256);

      // Random traffic with occasional resets.
      begin
         bit cof;
         cof = 1'b0;
         for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 5) == 0) cof = ~cof;
            if ($urandom_range(0, 699) == 0) do_reset();
            cyc(cof, 3'($urandom_range(0, 7)));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
